blackjack_autoplayer: RTL and testbench

- Player-side initiator for the Blackjack game core: drives the core's active-high game reset and its hit and stay inputs, and consumes its soma, win, lose and tie outputs.
- Runs a fixed threshold strategy: hit while the sum is below THRESHOLD, otherwise stay.
- Tallies round outcomes in saturating counters.
- Sits beside the game core for self-play regression and for board demo mode.

---
 rtl/blackjack_autoplayer_if.sv | 22 ++
 rtl/blackjack_autoplayer.sv | 244 ++++++++++++++++++++++++
 tb/tb_blackjack_autoplayer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/blackjack_autoplayer_if.sv
// Link between the autoplayer and the Blackjack game core.
// The autoplayer is the master: it drives the core reset and the
// hit/stay requests, and observes the hand sum and the result flags.
interface blackjack_autoplayer_if;
  logic [5:0] soma;
  logic       win;
  logic       lose;
  logic       tie;
  logic       game_rst;
  logic       hit;
  logic       stay;

  modport master (
    input  soma, win, lose, tie,
    output game_rst, hit, stay
  );

  modport slave (
    output soma, win, lose, tie,
    input  game_rst, hit, stay
  );
endinterface

// File: rtl/blackjack_autoplayer.sv
// Blackjack autoplayer: resets the game core, plays a fixed threshold
// strategy (hit below THRESHOLD, otherwise stay), and tallies round
// outcomes in saturating counters. Every output is a register.
module blackjack_autoplayer #(
  parameter int THRESHOLD     = 17,
  parameter int MAX_HITS      = 9,
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int HIT_CYCLES    = 8,
  parameter int WAIT_CYCLES   = 32,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  continuous,
  blackjack_autoplayer_if.master core,
  output logic                  busy,
  output logic                  round_done,
  output logic [1:0]            last_result,
  output logic [3:0]            hit_count,
  output logic [CNT_W-1:0]      win_cnt,
  output logic [CNT_W-1:0]      lose_cnt,
  output logic [CNT_W-1:0]      tie_cnt,
  output logic                  timeout_err,
  output logic                  multi_err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_GAME_RST,
    S_SETTLE,
    S_DECIDE,
    S_HIT,
    S_HIT_WAIT,
    S_STAY,
    S_RESULT,
    S_DONE
  } state_t;

  // Timer loads are count-1 because expiry is the cycle the timer reads 0.
  localparam logic [7:0] RST_LOAD    = 8'(RST_CYCLES - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] HIT_LOAD    = 8'(HIT_CYCLES - 1);
  localparam logic [7:0] WAIT_LOAD   = 8'(WAIT_CYCLES - 1);
  localparam logic [7:0] STAY_LOAD   = 8'd254;
  localparam logic [5:0] THR_SOMA    = 6'(THRESHOLD);
  localparam logic [3:0] MAX_HC      = 4'(MAX_HITS);

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Result encoding with priority win > lose > tie; 00 when none is high.
  function automatic logic [1:0] result_code(input logic w, input logic l, input logic t);
    if (w)      return 2'b01;
    else if (l) return 2'b10;
    else if (t) return 2'b11;
    else        return 2'b00;
  endfunction

  state_t           r_state;
  logic [7:0]       r_timer;
  logic [5:0]       r_snap;
  logic             r_game_rst;
  logic             r_hit;
  logic             r_stay;
  logic             r_busy;
  logic             r_round_done;
  logic [1:0]       r_last;
  logic [3:0]       r_hit_count;
  logic [CNT_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_lose_cnt;
  logic [CNT_W-1:0] r_tie_cnt;
  logic             r_timeout_err;
  logic             r_multi_err;

  logic             w_any_res;
  logic             w_multi;
  logic [1:0]       w_code;

  assign w_any_res = core.win | core.lose | core.tie;
  assign w_multi   = (core.win & core.lose) | (core.win & core.tie) | (core.lose & core.tie);
  assign w_code    = result_code(core.win, core.lose, core.tie);

  assign core.game_rst = r_game_rst;
  assign core.hit      = r_hit;
  assign core.stay     = r_stay;
  assign busy          = r_busy;
  assign round_done    = r_round_done;
  assign last_result   = r_last;
  assign hit_count     = r_hit_count;
  assign win_cnt       = r_win_cnt;
  assign lose_cnt      = r_lose_cnt;
  assign tie_cnt       = r_tie_cnt;
  assign timeout_err   = r_timeout_err;
  assign multi_err     = r_multi_err;

  // Round sequencer: state, shared down-timer and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_timer       <= 8'd0;
      r_snap        <= 6'd0;
      r_game_rst    <= 1'b0;
      r_hit         <= 1'b0;
      r_stay        <= 1'b0;
      r_busy        <= 1'b0;
      r_round_done  <= 1'b0;
      r_last        <= 2'b00;
      r_hit_count   <= 4'd0;
      r_win_cnt     <= '0;
      r_lose_cnt    <= '0;
      r_tie_cnt     <= '0;
      r_timeout_err <= 1'b0;
      r_multi_err   <= 1'b0;
    end else begin
      r_round_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_GAME_RST;
            r_timer     <= RST_LOAD;
            r_game_rst  <= 1'b1;
            r_busy      <= 1'b1;
            r_hit_count <= 4'd0;
            r_last      <= 2'b00;
          end
        end

        S_GAME_RST: begin
          if (r_timer == 8'd0) begin
            r_state    <= S_SETTLE;
            r_timer    <= SETTLE_LOAD;
            r_game_rst <= 1'b0;
          end else begin
            r_timer <= r_timer - 8'd1;
          end
        end

        S_SETTLE: begin
          if (r_timer == 8'd0) r_state <= S_DECIDE;
          else                 r_timer <= r_timer - 8'd1;
        end

        S_DECIDE: begin
          if (w_any_res) begin
            r_state <= S_RESULT;
          end else if (core.soma > 6'd21) begin
            r_state <= S_STAY;
            r_stay  <= 1'b1;
            r_timer <= STAY_LOAD;
          end else if (core.soma < THR_SOMA && r_hit_count < MAX_HC) begin
            r_state     <= S_HIT;
            r_hit       <= 1'b1;
            r_snap      <= core.soma;
            r_hit_count <= r_hit_count + 4'd1;
            r_timer     <= HIT_LOAD;
          end else begin
            r_state <= S_STAY;
            r_stay  <= 1'b1;
            r_timer <= STAY_LOAD;
          end
        end

        S_HIT: begin
          if (r_timer == 8'd0) begin
            r_state <= S_HIT_WAIT;
            r_hit   <= 1'b0;
            r_timer <= WAIT_LOAD;
          end else begin
            r_timer <= r_timer - 8'd1;
          end
        end

        // A card that never shows up still returns to DECIDE; the hit cap
        // keeps a stuck core from drawing forever.
        S_HIT_WAIT: begin
          if (w_any_res) begin
            r_state <= S_RESULT;
          end else if (core.soma != r_snap) begin
            r_state <= S_DECIDE;
          end else if (r_timer == 8'd0) begin
            r_state       <= S_DECIDE;
            r_timeout_err <= 1'b1;
          end else begin
            r_timer <= r_timer - 8'd1;
          end
        end

        S_STAY: begin
          if (w_any_res) begin
            r_state <= S_RESULT;
            r_stay  <= 1'b0;
          end else if (r_timer == 8'd0) begin
            r_state       <= S_DONE;
            r_stay        <= 1'b0;
            r_timeout_err <= 1'b1;
            r_last        <= 2'b00;
            r_round_done  <= 1'b1;
          end else begin
            r_timer <= r_timer - 8'd1;
          end
        end

        S_RESULT: begin
          r_last <= w_code;
          case (w_code)
            2'b01:   r_win_cnt  <= sat_inc(r_win_cnt);
            2'b10:   r_lose_cnt <= sat_inc(r_lose_cnt);
            2'b11:   r_tie_cnt  <= sat_inc(r_tie_cnt);
            default: ;
          endcase
          if (w_multi) r_multi_err <= 1'b1;
          r_state      <= S_DONE;
          r_round_done <= 1'b1;
        end

        S_DONE: begin
          if (continuous) begin
            r_state     <= S_GAME_RST;
            r_timer     <= RST_LOAD;
            r_game_rst  <= 1'b1;
            r_hit_count <= 4'd0;
            r_last      <= 2'b00;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_game_rst <= 1'b0;
          r_hit      <= 1'b0;
          r_stay     <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blackjack_autoplayer.sv
// Bench for blackjack_autoplayer: a small game-core emulator reacts to the
// hit/stay requests, a table of hand-computed rounds plus randomized rounds
// checked against a strategy-level model, and hand sequences for continuous
// play with counter saturation and asynchronous reset mid-hit.
`timescale 1ns/1ps
module tb_blackjack_autoplayer;
  localparam int TH   = 17;
  localparam int MAXH = 9;
  localparam int RSTC = 4;
  localparam int HITC = 8;
  localparam int CW   = 2;
  localparam int CMAX = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic          busy, round_done, timeout_err, multi_err;
  logic [1:0]    last_result;
  logic [3:0]    hit_count;
  logic [CW-1:0] win_cnt, lose_cnt, tie_cnt;

  int checks = 0;
  int errors = 0;
  int grst_pulses = 0;

  blackjack_autoplayer_if bif();

  blackjack_autoplayer #(.CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .continuous  (continuous),
    .core        (bif.master),
    .busy        (busy),
    .round_done  (round_done),
    .last_result (last_result),
    .hit_count   (hit_count),
    .win_cnt     (win_cnt),
    .lose_cnt    (lose_cnt),
    .tie_cnt     (tie_cnt),
    .timeout_err (timeout_err),
    .multi_err   (multi_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  // Pulse-width and request-exclusivity watcher.
  initial begin
    int hw, gw, dw;
    hw = 0; gw = 0; dw = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        hw = 0; gw = 0; dw = 0;
      end else begin
        if (bif.hit) hw++;
        else if (hw != 0) begin chk("hit_width", hw, HITC); hw = 0; end
        if (bif.game_rst) gw++;
        else if (gw != 0) begin chk("game_rst_width", gw, RSTC); grst_pulses++; gw = 0; end
        if (round_done) dw++;
        else if (dw != 0) begin chk("round_done_width", dw, 1); dw = 0; end
        if (bif.hit || bif.stay || bif.game_rst)
          chk("req_exclusive", int'(bif.hit) + int'(bif.stay) + int'(bif.game_rst), 1);
      end
    end
  end

  // Strategy-level reference: play the hand by the threshold rule.
  function automatic void model(input int s0, input logic [35:0] cards, input logic [2:0] res,
                                input bit early, output int hits, output bit stayed,
                                output bit to, output logic [1:0] last, output bit multi);
    int s;
    s = s0; hits = 0; stayed = 0; to = 0;
    if (!(early && res != 3'b000)) begin
      while (s <= 21 && s < TH && hits < MAXH) begin
        int c;
        c = int'(cards[hits*4 +: 4]);
        if (c == 0) to = 1;
        s += c;
        hits++;
      end
      stayed = 1;
      if (res == 3'b000) to = 1;
    end
    last  = res[2] ? 2'b01 : res[1] ? 2'b10 : res[0] ? 2'b11 : 2'b00;
    multi = (int'(res[2]) + int'(res[1]) + int'(res[0])) >= 2;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    continuous = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  // Play nrounds rounds, emulating the core: each card lands two cycles
  // after a hit pulse ends, the result rises shortly after stay rises
  // (or is already high when early is set), and game_rst restores the hand.
  task automatic run_round(input logic [5:0] s0, input logic [35:0] cards, input logic [2:0] res,
                           input bit early, input int nrounds,
                           output int hits, output bit stay_seen, output int rd);
    int cyc, apply_at, raise_at, ci;
    bit fin, prev_hit, prev_stay;
    bif.soma = s0;
    {bif.win, bif.lose, bif.tie} = early ? res : 3'b000;
    continuous = (nrounds > 1);
    start = 1'b1;
    hits = 0; stay_seen = 0; rd = 0; ci = 0; cyc = 0;
    apply_at = -1; raise_at = -1; fin = 0; prev_hit = 0; prev_stay = 0;
    while (!fin && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (busy) start = 1'b0;
      if (bif.game_rst) begin
        bif.soma = s0;
        if (!early) {bif.win, bif.lose, bif.tie} = 3'b000;
        hits = 0; stay_seen = 0; ci = 0; apply_at = -1; raise_at = -1;
      end
      if (bif.hit && !prev_hit) hits++;
      if (!bif.hit && prev_hit) apply_at = cyc + 2;
      if (cyc == apply_at && ci < 9) begin
        bif.soma = bif.soma + 6'(cards[ci*4 +: 4]);
        ci++;
      end
      if (bif.stay && !prev_stay) begin
        stay_seen = 1;
        raise_at = cyc + 1 + int'($urandom_range(0, 3));
      end
      if (cyc == raise_at) {bif.win, bif.lose, bif.tie} = res;
      if (round_done) begin
        rd++;
        if (rd >= nrounds) continuous = 1'b0;
      end
      if (rd >= nrounds && !busy) fin = 1;
      prev_hit = bif.hit;
      prev_stay = bif.stay;
    end
    {bif.win, bif.lose, bif.tie} = 3'b000;
    start = 1'b0;
    continuous = 1'b0;
    chk("round_finished", int'(fin), 1);
  endtask

  task automatic check_round(input string tag, input int ehits, input bit estay,
                             input logic [1:0] elast, input bit emulti, input bit eto,
                             input int ew, input int el, input int et,
                             input int hits, input bit stay_seen, input int rd);
    chk({tag, ".hit_count"}, int'(hit_count), ehits);
    chk({tag, ".hit_pulses"}, hits, ehits);
    chk({tag, ".stay_seen"}, int'(stay_seen), int'(estay));
    chk({tag, ".last_result"}, int'(last_result), int'(elast));
    chk({tag, ".multi_err"}, int'(multi_err), int'(emulti));
    chk({tag, ".timeout_err"}, int'(timeout_err), int'(eto));
    chk({tag, ".win_cnt"}, int'(win_cnt), ew);
    chk({tag, ".lose_cnt"}, int'(lose_cnt), el);
    chk({tag, ".tie_cnt"}, int'(tie_cnt), et);
    chk({tag, ".round_done_pulses"}, rd, 1);
    chk({tag, ".busy_idle"}, int'(busy), 0);
  endtask

  typedef struct {
    string       name;
    int          s0;
    logic [35:0] cards;
    logic [2:0]  res;     // {win, lose, tie}
    bit          early;
    int          hits;
    bit          stayed;
    logic [1:0]  last;
    bit          multi;
    bit          to;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int hits, rd, n, mw, ml, mt;
    bit st, mto, mmu;
    logic [35:0] cards;

    bif.soma = 6'd0;
    {bif.win, bif.lose, bif.tie} = 3'b000;

    vecs[0] = '{"stand18",     18, 36'h0,          3'b010, 1'b0, 0, 1'b1, 2'b10, 1'b0, 1'b0};
    vecs[1] = '{"hit_seq",     10, 36'h000000045,  3'b100, 1'b0, 2, 1'b1, 2'b01, 1'b0, 1'b0};
    vecs[2] = '{"hit_timeout", 12, 36'h0,          3'b001, 1'b0, 9, 1'b1, 2'b11, 1'b0, 1'b1};
    vecs[3] = '{"win_tie",     20, 36'h0,          3'b101, 1'b0, 0, 1'b1, 2'b01, 1'b1, 1'b0};
    vecs[4] = '{"early_lose",   5, 36'h0,          3'b010, 1'b1, 0, 1'b0, 2'b10, 1'b0, 1'b0};
    vecs[5] = '{"bust25",      25, 36'h0,          3'b010, 1'b0, 0, 1'b1, 2'b10, 1'b0, 1'b0};
    vecs[6] = '{"edge16",      16, 36'h000000001,  3'b011, 1'b0, 1, 1'b1, 2'b10, 1'b1, 1'b0};
    vecs[7] = '{"stay_tmo",    19, 36'h0,          3'b000, 1'b0, 0, 1'b1, 2'b00, 1'b0, 1'b1};

    // Reset state
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst.busy", int'(busy), 0);
    chk("rst.game_rst", int'(bif.game_rst), 0);
    chk("rst.hit", int'(bif.hit), 0);
    chk("rst.stay", int'(bif.stay), 0);
    chk("rst.round_done", int'(round_done), 0);
    chk("rst.last_result", int'(last_result), 0);
    chk("rst.hit_count", int'(hit_count), 0);
    chk("rst.counters", int'(win_cnt) + int'(lose_cnt) + int'(tie_cnt), 0);
    chk("rst.errs", int'(timeout_err) + int'(multi_err), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_no_start.busy", int'(busy), 0);

    // Table-driven rounds, each from a fresh reset
    for (int i = 0; i < 8; i++) begin
      do_reset();
      run_round(6'(vecs[i].s0), vecs[i].cards, vecs[i].res, vecs[i].early, 1, hits, st, rd);
      check_round(vecs[i].name, vecs[i].hits, vecs[i].stayed, vecs[i].last, vecs[i].multi,
                  vecs[i].to, int'(vecs[i].last == 2'b01), int'(vecs[i].last == 2'b10),
                  int'(vecs[i].last == 2'b11), hits, st, rd);
    end

    // Randomized rounds against the strategy model
    mw = 0; ml = 0; mt = 0; mto = 0; mmu = 0;
    for (int i = 0; i < 30; i++) begin
      int s0, eh;
      logic [2:0] res;
      bit early, es, eto, emu;
      logic [1:0] el;
      if (i % 5 == 0) begin
        do_reset();
        mw = 0; ml = 0; mt = 0; mto = 0; mmu = 0;
      end
      s0 = int'($urandom_range(2, 30));
      for (int k = 0; k < 9; k++)
        cards[k*4 +: 4] = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 11));
      res = 3'($urandom_range(0, 7));
      early = ($urandom_range(0, 4) == 0);
      model(s0, cards, res, early, eh, es, eto, el, emu);
      if (el == 2'b01 && mw < CMAX) mw++;
      if (el == 2'b10 && ml < CMAX) ml++;
      if (el == 2'b11 && mt < CMAX) mt++;
      mto = mto | eto;
      mmu = mmu | emu;
      run_round(6'(s0), cards, res, early, 1, hits, st, rd);
      check_round("rand", eh, es, el, mmu, mto, mw, ml, mt, hits, st, rd);
    end

    // Continuous play: four forced wins, counter saturates at 3
    do_reset();
    n = grst_pulses;
    run_round(6'd18, 36'h0, 3'b100, 1'b0, 4, hits, st, rd);
    chk("cont.round_done_pulses", rd, 4);
    chk("cont.game_rst_pulses", grst_pulses - n, 4);
    chk("cont.win_cnt_sat", int'(win_cnt), CMAX);
    chk("cont.last_result", int'(last_result), 1);
    chk("cont.busy_idle", int'(busy), 0);

    // Asynchronous reset while hit is high
    do_reset();
    run_round(6'd18, 36'h0, 3'b100, 1'b0, 1, hits, st, rd);
    chk("async.pre_win_cnt", int'(win_cnt), 1);
    bif.soma = 6'd10;
    start = 1'b1;
    n = 0;
    while (!bif.hit && n < 200) begin
      @(negedge clk);
      n++;
      if (busy) start = 1'b0;
    end
    start = 1'b0;
    chk("async.hit_reached", int'(bif.hit), 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async.hit", int'(bif.hit), 0);
    chk("async.busy", int'(busy), 0);
    chk("async.win_cnt", int'(win_cnt), 0);
    chk("async.hit_count", int'(hit_count), 0);
    chk("async.stay_game_rst", int'(bif.stay) + int'(bif.game_rst), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("async.stays_idle", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
